// File: rtl/countdown_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : countdown_scheduler_if
// Brief    : Channel load/cancel strobes, shared-decrementer operand/result
//            and per-channel status bundle for countdown_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface countdown_scheduler_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32
);
    logic [NCH-1:0]       load_en;
    logic [NCH*WIDTH-1:0] load_value;
    logic [NCH-1:0]       cancel;
    logic [WIDTH-1:0]     dec_a;
    logic [WIDTH-1:0]     dec_out;
    logic [NCH-1:0]       grant;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       expire;
    logic [NCH*WIDTH-1:0] count;

    modport master (
        output load_en, load_value, cancel, dec_out,
        input  dec_a, grant, busy, expire, count
    );

    modport slave (
        input  load_en, load_value, cancel, dec_out,
        output dec_a, grant, busy, expire, count
    );
endinterface
`default_nettype wire

// File: rtl/countdown_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : countdown_scheduler
// Brief    : NCH countdown channels sharing one external decrementer through
//            a round-robin arbiter; one-cycle expire pulse on completion.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_scheduler #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32
) (
    input  wire                     clk,
    input  wire                     rst,
    countdown_scheduler_if.slave    bus
);
    localparam int PTR_W = $clog2(NCH);

    logic [NCH*WIDTH-1:0] count_q, count_d;
    logic [NCH-1:0]       busy_q, busy_d;
    logic [NCH-1:0]       expire_q, expire_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;

    logic [NCH-1:0]       eligible;
    logic [NCH-1:0]       grant;
    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W:0]       cand;
    logic [WIDTH-1:0]     cnt_arr [NCH];
    logic                 dec_zero;

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign cnt_arr[i] = count_q[i*WIDTH +: WIDTH];
    end

    // Channels touched by load or cancel this cycle must not consume the decrementer.
    assign eligible = busy_q & ~bus.load_en & ~bus.cancel & {NCH{~rst}};

    always_comb begin : arbiter
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NCH)) begin
                cand = cand - (PTR_W+1)'(NCH);
            end
            if (!grant_found && eligible[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin : grant_decode
        grant = '0;
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign dec_zero = (bus.dec_out == '0);

    always_comb begin : next_state
        count_d  = count_q;
        busy_d   = busy_q;
        expire_d = '0;
        ptr_d    = ptr_q;
        for (int i = 0; i < NCH; i++) begin
            if (bus.load_en[i]) begin
                count_d[i*WIDTH +: WIDTH] = bus.load_value[i*WIDTH +: WIDTH];
                busy_d[i]   = |bus.load_value[i*WIDTH +: WIDTH];
                expire_d[i] = ~|bus.load_value[i*WIDTH +: WIDTH];
            end else if (bus.cancel[i]) begin
                busy_d[i] = 1'b0;
            end else if (grant[i]) begin
                count_d[i*WIDTH +: WIDTH] = bus.dec_out;
                busy_d[i]   = ~dec_zero;
                expire_d[i] = dec_zero;
            end
        end
        if (grant_found) begin
            ptr_d = (grant_idx == PTR_W'(NCH-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            busy_q   <= '0;
            expire_q <= '0;
            ptr_q    <= '0;
        end else begin
            count_q  <= count_d;
            busy_q   <= busy_d;
            expire_q <= expire_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.grant  = grant;
    assign bus.dec_a  = grant_found ? cnt_arr[grant_idx] : '0;
    assign bus.busy   = busy_q;
    assign bus.expire = expire_q;
    assign bus.count  = count_q;

endmodule
`default_nettype wire
